control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Moore FSM sequencer for the simple two-register datapath: A, B and result registers, 2-input ALU and write-data muxes.
- Drives register reset, write enables, operand/ALU/data selects.
- Sequence: load A, load B, then loop "compare, A <= A - B" until the datapath equality flag `eq` is set, then park in DONE.
- Sits between the datapath and its clock/reset; it is the only driver of datapath control lines.

Parameters:
- none; encodings are fixed constants in the shared package.

Ports:
- clk  input  1  system clock, rising-edge.
- resControl  input  1  reset, asynchronous, active-low.
- eq  input  1  datapath equality flag (A == B), sampled on rising edge.
- resReg  output  3  active-low register resets: bit0 A, bit1 B, bit2 result.
- wen  output  2  one-hot write enables: bit0 A, bit1 B; 00 = no write.
- wsel  output  1  internal write source: 0 = ALU result, 1 = reserved (swap path); always 0 in this block.
- asel  output  2  ALU operand A source: 00 = A, 01 = B, 10 = const 0, 11 = const 1.
- bsel  output  2  ALU operand B source, same encoding as asel.
- datasel  output  1  write data: 0 = external input, 1 = internal (wsel mux).
- alusel  output  2  ALU op: 00 = add, 01 = sub (a-b), 10 = pass a, 11 = compare.

Behaviour:
- 3-bit state register, async cleared to INIT while resControl = 0.
- Outputs are purely combinational from state; there are no output registers.
- States and encodings:
  - INIT = 0
  - LOAD_A = 1
  - LOAD_B = 2
  - CMP = 3
  - EXEC = 4
  - DONE = 5
- Transitions:
  - INIT -> LOAD_A
  - LOAD_A -> LOAD_B
  - LOAD_B -> CMP
  - CMP -> DONE if eq = 1, else EXEC
  - EXEC -> CMP
  - DONE -> DONE
  - Codes 6 and 7 -> INIT, with INIT outputs.
- Default outputs unless overridden below: resReg = 111, wen = 00, wsel = 0, asel = 00, bsel = 00, datasel = 0, alusel = 00.
- INIT: resReg = 000 (all datapath registers held in reset); all other outputs at default.
- LOAD_A: wen = 01, datasel = 0.
- LOAD_B: wen = 10, datasel = 0.
- CMP: asel = 00, bsel = 01, alusel = 11, wen = 00; eq is sampled only here.
- EXEC: wen = 01, datasel = 1, wsel = 0, asel = 00, bsel = 01, alusel = 01 (A <= A - B).
- DONE: alusel = 10, asel = 00 (A presented on ALU output), wen = 00.
- Reset value of every output equals the INIT outputs.
- Timing after reset release, counting the first rising edge as edge 1:
  - INIT during cycle 0
  - LOAD_A during cycle 1
  - LOAD_B during cycle 2
  - first CMP during cycle 3
- Loop period is 2 cycles (CMP, EXEC).
- eq in any state other than CMP is ignored.
- Reset asserted mid-operation forces INIT immediately, asynchronously, with resReg = 000 the same instant.
- Only a new reset leaves DONE.

Optional Feature:
- Macro: CONTROL_RESTART_EN.
- When defined:
  - DONE lasts exactly one cycle, then goes to LOAD_A; the block runs back-to-back operations without reset.
  - The datapath registers are not re-reset on restart.
- When undefined: DONE is absorbing, as specified above.

Decomposition:
- Shared package control_pkg holds:
  - state encodings
  - asel/bsel source codes
  - alusel op codes
  - wen bit positions
  - resReg bit positions
- No sub-module: single always_ff for the state register, single always_comb for next state and outputs.

Test Plan:
- Hold resControl = 0 for 3 cycles -> state INIT, resReg = 000, wen = 00, alusel = 00; release -> next edge LOAD_A with wen = 01, datasel = 0, resReg = 111.
- eq = 0 constant after release -> LOAD_B (wen = 10), then CMP (alusel = 11, bsel = 01), EXEC (wen = 01, datasel = 1, alusel = 01), CMP, EXEC... alternating every cycle.
- eq = 0 for 12 cycles after release, then eq = 1 -> on the next CMP edge the state moves to DONE: wen = 00, alusel = 10, which holds for 10+ cycles.
- eq = 1 during LOAD_A, LOAD_B and EXEC but 0 in CMP -> no early exit; FSM still enters EXEC.
- Assert resControl = 0 asynchronously mid-EXEC, between clock edges -> outputs switch to INIT values (resReg = 000, wen = 00) without waiting for clk.
- With CONTROL_RESTART_EN: reach DONE -> one cycle later LOAD_A (wen = 01), resReg stays 111.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared encodings for the two-register datapath sequencer: state codes,
// ALU operand sources, ALU ops and control-bit positions.
package control_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_CMP    = 3'd3,
        ST_EXEC   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // ALU operand source codes (asel / bsel)
    localparam logic [1:0] SRC_A    = 2'b00;
    localparam logic [1:0] SRC_B    = 2'b01;
    localparam logic [1:0] SRC_ZERO = 2'b10;
    localparam logic [1:0] SRC_ONE  = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;
    localparam logic [1:0] ALU_CMP  = 2'b11;

    localparam int WEN_A_BIT = 0;
    localparam int WEN_B_BIT = 1;

    localparam int RES_A_BIT   = 0;
    localparam int RES_B_BIT   = 1;
    localparam int RES_OUT_BIT = 2;

    localparam logic DATA_EXT = 1'b0;
    localparam logic DATA_INT = 1'b1;
    localparam logic WSEL_ALU = 1'b0;

endpackage

// File: rtl/control_unit_if.sv
// Control/status bundle between the sequencer (master) and the datapath (slave).
interface control_unit_if;

    logic       eq;
    logic [2:0] resReg;
    logic [1:0] wen;
    logic       wsel;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic       datasel;
    logic [1:0] alusel;

    modport master (
        input  eq,
        output resReg, wen, wsel, asel, bsel, datasel, alusel
    );

    modport slave (
        output eq,
        input  resReg, wen, wsel, asel, bsel, datasel, alusel
    );

endinterface

// File: rtl/control_unit.sv
// Moore sequencer: load A, load B, then loop compare / A <= A - B until eq, park in DONE.
// Optional macro CONTROL_RESTART_EN: DONE lasts one cycle and restarts at LOAD_A.
module control_unit
    import control_pkg::*;
(
    input  logic           clk,
    input  logic           resControl,
    control_unit_if.master bus
);

    state_e     r_state;
    state_e     w_next_state;
    logic [2:0] w_resReg;
    logic [1:0] w_wen;
    logic       w_wsel;
    logic [1:0] w_asel;
    logic [1:0] w_bsel;
    logic       w_datasel;
    logic [1:0] w_alusel;

    always_ff @(posedge clk or negedge resControl) begin
        if (!resControl) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_INIT;
        w_resReg     = 3'b111;
        w_wen        = 2'b00;
        w_wsel       = WSEL_ALU;
        w_asel       = SRC_A;
        w_bsel       = SRC_A;
        w_datasel    = DATA_EXT;
        w_alusel     = ALU_ADD;

        case (r_state)
            ST_INIT: begin
                w_resReg[RES_A_BIT]   = 1'b0;
                w_resReg[RES_B_BIT]   = 1'b0;
                w_resReg[RES_OUT_BIT] = 1'b0;
                w_next_state          = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                w_wen[WEN_A_BIT] = 1'b1;
                w_datasel        = DATA_EXT;
                w_next_state     = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                w_wen[WEN_B_BIT] = 1'b1;
                w_datasel        = DATA_EXT;
                w_next_state     = ST_CMP;
            end
            ST_CMP: begin
                w_asel       = SRC_A;
                w_bsel       = SRC_B;
                w_alusel     = ALU_CMP;
                w_next_state = bus.eq ? ST_DONE : ST_EXEC;
            end
            ST_EXEC: begin
                w_wen[WEN_A_BIT] = 1'b1;
                w_datasel        = DATA_INT;
                w_wsel           = WSEL_ALU;
                w_asel           = SRC_A;
                w_bsel           = SRC_B;
                w_alusel         = ALU_SUB;
                w_next_state     = ST_CMP;
            end
            ST_DONE: begin
                w_asel   = SRC_A;
                w_alusel = ALU_PASS;
`ifdef CONTROL_RESTART_EN
                // Restart skips INIT so the datapath registers keep their contents.
                w_next_state = ST_LOAD_A;
`else
                w_next_state = ST_DONE;
`endif
            end
            default: begin
                // Illegal codes behave exactly like INIT.
                w_resReg     = 3'b000;
                w_next_state = ST_INIT;
            end
        endcase
    end

    assign bus.resReg  = w_resReg;
    assign bus.wen     = w_wen;
    assign bus.wsel    = w_wsel;
    assign bus.asel    = w_asel;
    assign bus.bsel    = w_bsel;
    assign bus.datasel = w_datasel;
    assign bus.alusel  = w_alusel;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a cycle-count reference model predicts outputs,
// a monitor compares them after each rising edge.
module tb_control_unit;

    typedef enum int {K_INIT, K_LOAD_A, K_LOAD_B, K_CMP, K_EXEC, K_DONE} kind_e;

    logic clk;
    logic resControl;
    control_unit_if cu_bus ();

    control_unit dut (
        .clk        (clk),
        .resControl (resControl),
        .bus        (cu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [12:0] exp_q[$];

    // Reference model: edges since reset release, plus a finished flag.
    int m_n    = 0;
    bit m_done = 0;

    function automatic kind_e model_kind();
        if (m_done)      return K_DONE;
        if (m_n == 0)    return K_INIT;
        if (m_n == 1)    return K_LOAD_A;
        if (m_n == 2)    return K_LOAD_B;
        if (((m_n - 3) % 2) == 0) return K_CMP;
        return K_EXEC;
    endfunction

    // {resReg, wen, wsel, asel, bsel, datasel, alusel}
    function automatic logic [12:0] exp_out(kind_e k);
        case (k)
            K_INIT:   return {3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00};
            K_LOAD_A: return {3'b111, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00};
            K_LOAD_B: return {3'b111, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00};
            K_CMP:    return {3'b111, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 2'b11};
            K_EXEC:   return {3'b111, 2'b01, 1'b0, 2'b00, 2'b01, 1'b1, 2'b01};
            default:  return {3'b111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10};
        endcase
    endfunction

    function automatic logic [12:0] dut_out();
        return {cu_bus.resReg, cu_bus.wen, cu_bus.wsel, cu_bus.asel,
                cu_bus.bsel, cu_bus.datasel, cu_bus.alusel};
    endfunction

    task automatic model_edge(input logic eq_v);
        if (m_done) begin
`ifdef CONTROL_RESTART_EN
            m_done = 0;
            m_n    = 1;
`endif
        end else if (model_kind() == K_CMP && eq_v) begin
            m_done = 1;
        end else begin
            m_n++;
        end
    endtask

    // One clock of stimulus: drive at the falling edge, predict the next rising edge.
    task automatic cycle(input logic rst_v, input logic eq_v);
        @(negedge clk);
        resControl = rst_v;
        cu_bus.eq  = eq_v;
        if (!rst_v) begin
            m_n    = 0;
            m_done = 0;
        end else begin
            model_edge(eq_v);
        end
        exp_q.push_back(exp_out(model_kind()));
    endtask

    task automatic check_now(input string name, input logic [12:0] exp_v);
        logic [12:0] act;
        act = dut_out();
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %013b expected %013b", name, act, exp_v);
    endtask

    // Monitor: one comparison per rising edge while predictions are pending.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [12:0] e;
                e = exp_q.pop_front();
                check_now("edge_outputs", e);
            end
        end
    end

    initial begin
        int guard;
        resControl = 1'b0;
        cu_bus.eq  = 1'b0;
        #2;
        check_now("reset_init", exp_out(K_INIT));

        // Reset held, then eq low for 12 cycles, then high until well past DONE.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1);

        // eq high everywhere except CMP: no early exit allowed.
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            logic e;
            e = (model_kind() == K_CMP) ? 1'b0 : 1'b1;
            cycle(1'b1, e);
        end

        // Asynchronous reset in the middle of an EXEC cycle.
        guard = 0;
        do begin
            logic e;
            e = (model_kind() == K_CMP) ? 1'b0 : 1'b1;
            cycle(1'b1, e);
            guard++;
        end while (model_kind() != K_EXEC && guard < 8);
        @(posedge clk);
        #3;
        check_now("exec_before_async", exp_out(K_EXEC));
        resControl = 1'b0;
        #1;
        check_now("async_reset", exp_out(K_INIT));
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);

        // Randomised run with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 59) != 0);
            cycle(r, ($urandom_range(0, 3) == 0));
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
